// File: rtl/ysyx_23060221_pkg.sv
// Shared definitions for the LSU slice.
//   - lsu_state_e : LSU controller states
//   - F3_*        : funct3 encodings for loads and stores
//   - RESP_*      : AXI response codes
package ysyx_23060221_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_WR   = 3'd3,
      S_B    = 3'd4,
      S_DONE = 3'd5
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060221_lsu_align.sv
// Combinational byte-lane steering for the LSU.
// Ports:
//   funct3   in  3  : access size / sign
//   offset   in  2  : byte offset within the 32-bit word (addr[1:0])
//   rdata    in  32 : raw word from the read data channel
//   wdata_in in  32 : store data (rs2)
//   ldata    out 32 : extracted, sign/zero-extended load result
//   wdata    out 32 : store data shifted into its byte lanes
//   wstrb    out 4  : byte strobes for the store
// Misaligned accesses simply shift; lanes past the word boundary are dropped.
module ysyx_23060221_lsu_align
   import ysyx_23060221_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata_in,
   output logic [31:0] ldata,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb
);

   logic [4:0]  w_shamt;
   logic [31:0] w_shifted;

   assign w_shamt   = {offset, 3'b000};
   assign w_shifted = rdata >> w_shamt;

   always_comb begin
      ldata = 32'h0;
      case (funct3)
         F3_LB:   ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_LBU:  ldata = {24'h0, w_shifted[7:0]};
         F3_LH:   ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_LHU:  ldata = {16'h0, w_shifted[15:0]};
         F3_LW:   ldata = w_shifted;
         default: ldata = 32'h0;
      endcase
   end

   assign wdata = wdata_in << w_shamt;

   always_comb begin
      wstrb = 4'b0000;
      case (funct3)
         F3_SB:   wstrb = 4'b0001 << offset;
         F3_SH:   wstrb = 4'b0011 << offset;
         F3_SW:   wstrb = 4'b1111;
         default: wstrb = 4'b0000;
      endcase
   end

endmodule

// File: rtl/ysyx_23060221_lsu.sv
// Load/store unit between EXU and WBU. Takes one instruction at a time,
// issues at most one AXI4-Lite-style transaction, and presents the
// extended load data plus forwarded ALU result/controls to WBU.
// Ports:
//   clk, rst (sync, active-low)
//   EXU side : EXU_valid, LSU_ready, addr, wdata_in, memread, memwrite,
//              funct3, res_in, regw_in, memtoreg_in
//   WBU side : LSU_valid, WBU_ready, dataout, res, regw, memtoreg, lsu_fault
//   Bus      : AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready),
//              AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//              B (bresp/bvalid/bready)
// Build option: LSU_MISALIGN_TRAP_EN -- misaligned lh/lhu/sh/lw/sw skip the
// bus and complete with lsu_fault=1, dataout=0, regw=0.
module ysyx_23060221_lsu
   import ysyx_23060221_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        EXU_valid,
   output logic        LSU_ready,
   input  logic [31:0] addr,
   input  logic [31:0] wdata_in,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] res_in,
   input  logic        regw_in,
   input  logic        memtoreg_in,
   output logic        LSU_valid,
   input  logic        WBU_ready,
   output logic [31:0] dataout,
   output logic [31:0] res,
   output logic        regw,
   output logic        memtoreg,
   output logic        lsu_fault,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   lsu_state_e  r_state, w_next;
   logic        r_ready;
   logic [31:0] r_addr, r_wdata_in, r_res, r_dataout;
   logic [2:0]  r_funct3;
   logic        r_memwrite, r_regw, r_memtoreg, r_fault;
   logic        r_aw_done, r_w_done;
   logic        w_trap, w_aw_fin, w_w_fin;
   logic [31:0] w_ldata, w_wdata;
   logic [3:0]  w_wstrb;

`ifdef LSU_MISALIGN_TRAP_EN
   logic w_half, w_word;
   assign w_half = (funct3 == F3_LH) || (funct3 == F3_LHU);
   assign w_word = (funct3 == F3_LW);
   assign w_trap = (memread | memwrite) &
                   ((w_half & addr[0]) | (w_word & (|addr[1:0])));
`else
   assign w_trap = 1'b0;
`endif

   // A channel is finished once its handshake has happened, either in an
   // earlier cycle (done flag) or right now.
   assign w_aw_fin = r_aw_done | awready;
   assign w_w_fin  = r_w_done  | wready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (EXU_valid) begin
               if (w_trap)        w_next = S_DONE;
               else if (memread)  w_next = S_AR;
               else if (memwrite) w_next = S_WR;
               else               w_next = S_DONE;
            end
         end
         S_AR:    if (arready) w_next = S_R;
         S_R:     if (rvalid) w_next = S_DONE;
         S_WR:    if (w_aw_fin && w_w_fin) w_next = S_B;
         S_B:     if (bvalid) w_next = S_DONE;
         S_DONE:  if (WBU_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_next;
         // Registered ready: high exactly when the state register is IDLE.
         r_ready <= (w_next == S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_addr     <= 32'h0;
         r_wdata_in <= 32'h0;
         r_res      <= 32'h0;
         r_dataout  <= 32'h0;
         r_funct3   <= 3'b000;
         r_memwrite <= 1'b0;
         r_regw     <= 1'b0;
         r_memtoreg <= 1'b0;
         r_fault    <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (EXU_valid) begin
                  r_addr     <= addr;
                  r_wdata_in <= wdata_in;
                  r_res      <= res_in;
                  r_funct3   <= funct3;
                  // Load wins if both are set, so the store flag is dropped.
                  r_memwrite <= memwrite & ~memread & ~w_trap;
                  r_regw     <= regw_in & ~w_trap;
                  r_memtoreg <= memtoreg_in;
                  r_fault    <= w_trap;
                  r_dataout  <= 32'h0;
                  r_aw_done  <= 1'b0;
                  r_w_done   <= 1'b0;
               end
            end
            S_R: begin
               if (rvalid) begin
                  r_dataout <= w_ldata;
                  r_fault   <= (rresp != RESP_OKAY);
               end
            end
            S_WR: begin
               if (awready) r_aw_done <= 1'b1;
               if (wready)  r_w_done  <= 1'b1;
            end
            S_B: begin
               if (bvalid) r_fault <= (bresp != RESP_OKAY);
            end
            default: ;
         endcase
      end
   end

   ysyx_23060221_lsu_align u_align (
      .funct3   (r_funct3),
      .offset   (r_addr[1:0]),
      .rdata    (rdata),
      .wdata_in (r_wdata_in),
      .ldata    (w_ldata),
      .wdata    (w_wdata),
      .wstrb    (w_wstrb)
   );

   assign LSU_ready = r_ready;
   assign LSU_valid = (r_state == S_DONE);
   assign lsu_fault = LSU_valid & r_fault;
   assign dataout   = r_dataout;
   assign res       = r_res;
   assign regw      = r_regw;
   assign memtoreg  = r_memtoreg;

   assign araddr  = {r_addr[31:2], 2'b00};
   assign arvalid = (r_state == S_AR);
   assign rready  = (r_state == S_R);

   assign awaddr  = {r_addr[31:2], 2'b00};
   assign awvalid = (r_state == S_WR) & ~r_aw_done;
   assign wvalid  = (r_state == S_WR) & ~r_w_done;
   assign wdata   = w_wdata;
   assign wstrb   = r_memwrite ? w_wstrb : 4'b0000;
   assign bready  = (r_state == S_B);

endmodule

// File: tb/tb_ysyx_23060221_lsu.sv
module tb_ysyx_23060221_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        EXU_valid, LSU_ready;
   logic [31:0] addr, wdata_in, res_in;
   logic        memread, memwrite, regw_in, memtoreg_in;
   logic [2:0]  funct3;
   logic        LSU_valid, WBU_ready;
   logic [31:0] dataout, res;
   logic        regw, memtoreg, lsu_fault;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rvalid, rready, awvalid, awready;
   logic        wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ysyx_23060221_lsu dut (
      .clk(clk), .rst(rst), .EXU_valid(EXU_valid), .LSU_ready(LSU_ready),
      .addr(addr), .wdata_in(wdata_in), .memread(memread), .memwrite(memwrite),
      .funct3(funct3), .res_in(res_in), .regw_in(regw_in), .memtoreg_in(memtoreg_in),
      .LSU_valid(LSU_valid), .WBU_ready(WBU_ready), .dataout(dataout), .res(res),
      .regw(regw), .memtoreg(memtoreg), .lsu_fault(lsu_fault),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Zero-wait load: accept T, arvalid T+1, rready T+2, LSU_valid T+3.
   task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] rd, input logic [1:0] rsp,
                          input logic [31:0] exp_data, input logic [31:0] exp_araddr,
                          input logic exp_fault);
      chk({tag, "_ready"}, LSU_ready, 1);
      EXU_valid = 1; memread = 1; memwrite = 0; addr = a; funct3 = f3;
      res_in = 32'h5555_AAAA; regw_in = 1; memtoreg_in = 1;
      WBU_ready = 1; arready = 1; rvalid = 0;
      tick();
      EXU_valid = 0;
      chk({tag, "_arvalid"}, arvalid, 1);
      chk({tag, "_araddr"}, araddr, exp_araddr);
      tick();
      chk({tag, "_rready"}, rready, 1);
      chk({tag, "_arvalid_off"}, arvalid, 0);
      rvalid = 1; rdata = rd; rresp = rsp;
      tick();
      rvalid = 0; rresp = 2'b00; arready = 0;
      chk({tag, "_valid"}, LSU_valid, 1);
      chk({tag, "_data"}, dataout, exp_data);
      chk({tag, "_fault"}, lsu_fault, exp_fault);
      chk({tag, "_memtoreg"}, memtoreg, 1);
      tick();
      chk({tag, "_idle"}, LSU_valid, 0);
   endtask

   task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] wd, input int awdly, input logic [1:0] rsp,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                           input logic [31:0] exp_awaddr, input logic exp_fault,
                           input int exp_awcnt, input int exp_wcnt);
      int awcnt, wcnt, c, vcnt;
      awcnt = 0; wcnt = 0; c = 0; vcnt = 0;
      chk({tag, "_ready"}, LSU_ready, 1);
      EXU_valid = 1; memread = 0; memwrite = 1; addr = a; funct3 = f3; wdata_in = wd;
      res_in = 32'h0; regw_in = 0; memtoreg_in = 0; WBU_ready = 1;
      tick();
      EXU_valid = 0;
      chk({tag, "_busy"}, LSU_ready, 0);
      while (!bready && c < 20) begin
         awready = (c >= awdly); wready = 1;
         if (LSU_valid) vcnt++;
         if (awvalid) begin
            awcnt++;
            chk({tag, "_awaddr"}, awaddr, exp_awaddr);
         end
         if (wvalid) begin
            wcnt++;
            chk({tag, "_wdata"}, wdata, exp_wdata);
            chk({tag, "_wstrb"}, {28'h0, wstrb}, {28'h0, exp_wstrb});
         end
         tick();
         c++;
      end
      awready = 0; wready = 0;
      chk({tag, "_bready"}, bready, 1);
      chk({tag, "_awcnt"}, awcnt, exp_awcnt);
      chk({tag, "_wcnt"}, wcnt, exp_wcnt);
      bvalid = 1; bresp = rsp;
      tick();
      bvalid = 0; bresp = 2'b00;
      if (LSU_valid) vcnt++;
      chk({tag, "_fault"}, lsu_fault, exp_fault);
      chk({tag, "_dataout"}, dataout, 0);
      tick();
      if (LSU_valid) vcnt++;
      tick();
      if (LSU_valid) vcnt++;
      chk({tag, "_vcnt"}, vcnt, 1);
      chk({tag, "_idle"}, LSU_ready, 1);
   endtask

   initial begin
      rst = 0; EXU_valid = 0; addr = 0; wdata_in = 0; memread = 0; memwrite = 0;
      funct3 = 0; res_in = 0; regw_in = 0; memtoreg_in = 0; WBU_ready = 0;
      arready = 0; rdata = 0; rresp = 0; rvalid = 0; awready = 0; wready = 0;
      bresp = 0; bvalid = 0;
      tick(); tick(); tick();
      chk("rst_ready", LSU_ready, 1);
      chk("rst_valid", LSU_valid, 0);
      chk("rst_busvalids", {arvalid, rready, awvalid, wvalid, bready}, 0);
      chk("rst_ctrl", {lsu_fault, regw, memtoreg}, 0);
      chk("rst_dataout", dataout, 0);
      chk("rst_res", res, 0);
      chk("rst_addrs", araddr | awaddr | wdata, 0);
      chk("rst_wstrb", {28'h0, wstrb}, 0);
      rst = 1;
      tick();

      do_load("lb",  32'h8000_0003, 3'b000, 32'h80FF_1234, 2'b00, 32'hFFFF_FF80, 32'h8000_0000, 0);
      do_load("lbu", 32'h8000_0003, 3'b100, 32'h80FF_1234, 2'b00, 32'h0000_0080, 32'h8000_0000, 0);
      do_load("lhu", 32'h8000_0002, 3'b101, 32'h9ABC_5678, 2'b00, 32'h0000_9ABC, 32'h8000_0000, 0);
      do_load("lh",  32'h8000_0002, 3'b001, 32'h9ABC_5678, 2'b00, 32'hFFFF_9ABC, 32'h8000_0000, 0);
      do_load("lw",  32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 32'h8000_0004, 0);
      do_load("lh0", 32'h8000_0000, 3'b001, 32'h1234_8001, 2'b00, 32'hFFFF_8001, 32'h8000_0000, 0);
      do_load("f3x", 32'h8000_0000, 3'b011, 32'hFFFF_FFFF, 2'b00, 32'h0000_0000, 32'h8000_0000, 0);
      do_load("rerr", 32'h8000_0008, 3'b010, 32'h0BAD_F00D, 2'b10, 32'h0BAD_F00D, 32'h8000_0008, 1);

      do_store("sh", 32'h8000_0002, 3'b001, 32'h0000_ABCD, 0, 2'b00,
               32'hABCD_0000, 4'b1100, 32'h8000_0000, 0, 1, 1);
      do_store("sb", 32'h8000_0001, 3'b000, 32'h0000_00EF, 0, 2'b00,
               32'h0000_EF00, 4'b0010, 32'h8000_0000, 0, 1, 1);
      do_store("sw_awdly", 32'h8000_0010, 3'b010, 32'h1234_5678, 3, 2'b00,
               32'h1234_5678, 4'b1111, 32'h8000_0010, 0, 4, 1);
      do_store("berr", 32'h8000_0020, 3'b000, 32'h0000_0011, 0, 2'b11,
               32'h0000_0011, 4'b0001, 32'h8000_0020, 1, 1, 1);

      // ALU op with WBU stalling, then a back-to-back op that must wait
      // for the DONE->IDLE transfer cycle.
      EXU_valid = 1; memread = 0; memwrite = 0; res_in = 32'h0000_1234;
      regw_in = 1; memtoreg_in = 0; WBU_ready = 0;
      tick();
      EXU_valid = 0;
      chk("alu_valid_t1", LSU_valid, 1);
      chk("alu_res", res, 32'h0000_1234);
      chk("alu_regw", regw, 1);
      chk("alu_dataout", dataout, 0);
      tick();
      chk("alu_hold1", LSU_valid, 1);
      chk("alu_hold1_res", res, 32'h0000_1234);
      tick();
      chk("alu_hold2", LSU_valid, 1);
      chk("alu_hold2_res", res, 32'h0000_1234);
      WBU_ready = 1; EXU_valid = 1; res_in = 32'h0000_0777;
      tick();
      chk("alu_xfer_valid", LSU_valid, 0);
      chk("alu_xfer_ready", LSU_ready, 1);
      tick();
      EXU_valid = 0;
      chk("alu2_valid", LSU_valid, 1);
      chk("alu2_res", res, 32'h0000_0777);
      tick();
      chk("alu2_idle", LSU_valid, 0);

`ifdef LSU_MISALIGN_TRAP_EN
      EXU_valid = 1; memread = 1; memwrite = 0; addr = 32'h8000_0002; funct3 = 3'b010;
      regw_in = 1; WBU_ready = 0; arready = 1;
      tick();
      EXU_valid = 0;
      chk("trap_arvalid", arvalid, 0);
      chk("trap_valid", LSU_valid, 1);
      chk("trap_fault", lsu_fault, 1);
      chk("trap_regw", regw, 0);
      chk("trap_dataout", dataout, 0);
      WBU_ready = 1;
      tick();
      arready = 0;
      chk("trap_arvalid2", arvalid, 0);
      chk("trap_idle", LSU_ready, 1);
`else
      do_load("lw_mis", 32'h8000_0002, 3'b010, 32'h1122_3344, 2'b00, 32'h0000_1122, 32'h8000_0000, 0);
`endif

      // Reset in the middle of a load aborts straight to IDLE.
      EXU_valid = 1; memread = 1; memwrite = 0; addr = 32'h8000_0040; funct3 = 3'b010;
      arready = 0;
      tick();
      EXU_valid = 0;
      chk("abort_arvalid", arvalid, 1);
      rst = 0;
      tick();
      chk("abort_arvalid_off", arvalid, 0);
      chk("abort_ready", LSU_ready, 1);
      chk("abort_valid", LSU_valid, 0);
      rst = 1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_23060221_lsu.md
# ysyx_23060221_lsu

Load/store unit between the execute stage and the write-back stage. It accepts one instruction at a time from EXU over a valid/ready handshake and performs at most one memory transaction on an AXI4-Lite-style data bus. For loads it produces a sign/zero-extended result. It forwards the ALU result and register-write controls unchanged, presenting them to WBU as `LSU_valid`/`dataout`.

## Interface
Parameters:
- none; widths fixed at 32-bit address/data.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `EXU_valid` in 1: upstream instruction valid.
- `LSU_ready` out 1: LSU can accept an instruction.
- `addr` in 32: effective address from ALU.
- `wdata_in` in 32: store data (rs2).
- `memread` in 1: instruction is a load.
- `memwrite` in 1: instruction is a store.
- `funct3` in 3: access size/sign.
- `res_in` in 32: ALU result.
- `regw_in` in 1: register-write enable.
- `memtoreg_in` in 1: write-back selects memory data.
- `LSU_valid` out 1: result valid to WBU.
- `WBU_ready` in 1: WBU accepts the result.
- `dataout` out 32: extended load data.
- `res` out 32: ALU result, forwarded.
- `regw` out 1: register-write enable, forwarded.
- `memtoreg` out 1: memory-data select, forwarded.
- `lsu_fault` out 1: bus error or misaligned access, qualified by `LSU_valid`.
- `araddr` out 32, `arvalid` out 1, `arready` in 1: read address channel.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1: read data channel.
- `awaddr` out 32, `awvalid` out 1, `awready` in 1: write address channel.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1: write data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: write response channel.

## Operation
- FSM states: IDLE, AR, R, WR, B, DONE.
- IDLE: `LSU_ready`=1. When `EXU_valid` is high, all inputs are registered and the next state is:
  - AR if `memread`;
  - WR if `memwrite`;
  - DONE otherwise.
  - `memread` and `memwrite` both set is illegal; the load takes priority.
- AR: `arvalid`=1, `araddr`={addr[31:2],2'b00}. On `arready`, go to R.
- R: `rready`=1. On `rvalid`, capture the extended `rdata`, set the fault flag if `rresp`≠0, and go to DONE.
- WR: `awvalid` and `wvalid` are raised together. Per-channel done flags track completion, so each channel deasserts independently on its own ready. When both are done, go to B.
- B: `bready`=1. On `bvalid`, set the fault flag if `bresp`≠0, and go to DONE.
- DONE: `LSU_valid`=1. All outputs hold stable until `WBU_ready`, then go to IDLE.
- Load extract: byte offset a=addr[1:0]; shifted = rdata >> (8·a).
  - funct3 000: sign-extend shifted[7:0].
  - funct3 100: zero-extend shifted[7:0].
  - funct3 001: sign-extend shifted[15:0].
  - funct3 101: zero-extend shifted[15:0].
  - funct3 010: full word.
  - Other funct3 values: result is 0.
- Store align: `wdata`=wdata_in << (8·a). `wstrb` is:
  - 0001<<a for sb;
  - 0011<<a for sh;
  - 1111 for sw.
- `dataout` is 0 for non-load instructions.

## Timing
- Reset values:
  - State IDLE.
  - `LSU_ready`=1.
  - `LSU_valid`, `arvalid`, `rready`, `awvalid`, `wvalid`, `bready`, `lsu_fault`, `regw`, `memtoreg` all 0.
  - `dataout`, `res`, `araddr`, `awaddr`, `wdata` all 0; `wstrb`=0.
- Non-memory op accepted at cycle T: `LSU_valid` at T+1.
- Load with zero-wait slave: accept T, `arvalid` T+1, `rready` T+2, `LSU_valid` T+3.
- Store with zero-wait slave: accept T, aw/w T+1, `bready` T+2, `LSU_valid` T+3.
- Once asserted, a valid (`arvalid`/`awvalid`/`wvalid`/`LSU_valid`) never drops before its ready, and its payload is stable while waiting.
- `LSU_ready` is registered and is 1 only in IDLE. No new instruction is accepted in the DONE→IDLE transfer cycle.
- Reset mid-transaction aborts immediately to IDLE with no bus wind-down. The bus slave shares `rst`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A lh/lhu/sh with addr[0]=1, or an lw/sw with addr[1:0]≠0, skips the bus entirely.
  - The FSM goes to DONE with `lsu_fault`=1, `dataout`=0, and `regw`=0.
- Not defined: no alignment check. Misaligned accesses use the lane shift above, and bytes past the word boundary are lost.

## Structure
- Shared package `ysyx_23060221_pkg` holds:
  - the FSM state enum;
  - funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - AXI response codes (OKAY=2'b00).
- Sub-module `ysyx_23060221_lsu_align`: purely combinational; performs load extract and store align (wdata/wstrb) from funct3 and offset.

## Test plan
- lb at 0x80000003 with rdata=0x80FF1234 → `dataout`=0xFFFFFF80 and `araddr`=0x80000000. lbu at the same address → 0x00000080.
- lhu at 0x80000002 with rdata=0x9ABC5678 → 0x00009ABC; lh at the same address → 0xFFFF9ABC.
- sh at 0x80000002, wdata_in=0x0000ABCD → `wdata`=0xABCD0000, `wstrb`=4'b1100.
- sw with `awready` delayed 3 cycles and `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` is held 4 cycles, `LSU_valid` appears exactly once.
- ALU op res_in=0x1234, regw_in=1, with `WBU_ready` low for 2 cycles → `LSU_valid`/`res` held for 3 cycles, then IDLE.
- With `LSU_MISALIGN_TRAP_EN`, lw at 0x80000002 → `arvalid` never rises, `LSU_valid` at T+1 with `lsu_fault`=1 and `regw`=0. A load with `rresp`=2'b10 → `lsu_fault`=1.
